sdram_init_seq: RTL and testbench

SDRAM_INIT_SEQ -- requirements
Module: sdram_init_seq

---
 rtl/sdram_init_seq.sv | 204 ++++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: CKE/NOP wait, precharge-all, auto-refresh burst, mode load.
// Define SDR_INIT_EXT_MODE_EN to add an extended mode register load (BA=01) before completion.
module sdram_init_seq #(
  parameter int unsigned T_PWR    = 100,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_RFC    = 7,
  parameter int unsigned NUM_REF  = 8,
  parameter int unsigned T_MRD    = 2,
  parameter logic [12:0] MODE_REG = 13'h033
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        init_req,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_init_done,
  output logic [3:0]  dbg_state
);

  // Command word {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam logic [15:0] PWR_M1  = 16'(T_PWR - 1);
  localparam logic [15:0] RP_M1   = 16'(T_RP - 1);
  localparam logic [15:0] RFC_M1  = 16'(T_RFC - 1);
  localparam logic [15:0] MRD_M1  = 16'(T_MRD - 1);
  localparam logic [7:0]  REF_NUM = 8'(NUM_REF);

  typedef enum logic [3:0] {
    IDLE,
    PWR_WAIT,
    PRECHARGE,
    TRP_WAIT,
    REFRESH,
    TRFC_WAIT,
    LOAD_MODE,
    TMRD_WAIT,
    DONE
`ifdef SDR_INIT_EXT_MODE_EN
    ,
    EXT_MODE,
    TEMRD_WAIT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dly_q, dly_d;
  logic [7:0]  ref_q, ref_d;

  logic        cke_d;
  logic [3:0]  cmd_d;
  logic [12:0] addr_d;
  logic [1:0]  ba_d;
  logic        done_d;

  // Each command state loads dly with (T_x - 1); a zero load moves straight on next cycle.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    ref_d   = ref_q;
    case (state_q)
      IDLE: begin
        state_d = PWR_WAIT;
        dly_d   = PWR_M1;
      end
      PWR_WAIT: begin
        if (dly_q == 16'd0) begin
          state_d = PRECHARGE;
          dly_d   = RP_M1;
          ref_d   = REF_NUM;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      PRECHARGE, TRP_WAIT: begin
        if (dly_q == 16'd0) begin
          state_d = REFRESH;
          dly_d   = RFC_M1;
          ref_d   = ref_q - 8'd1;
        end else begin
          state_d = TRP_WAIT;
          dly_d   = dly_q - 16'd1;
        end
      end
      REFRESH, TRFC_WAIT: begin
        if (dly_q == 16'd0) begin
          if (ref_q == 8'd0) begin
            state_d = LOAD_MODE;
            dly_d   = MRD_M1;
          end else begin
            state_d = REFRESH;
            dly_d   = RFC_M1;
            ref_d   = ref_q - 8'd1;
          end
        end else begin
          state_d = TRFC_WAIT;
          dly_d   = dly_q - 16'd1;
        end
      end
      LOAD_MODE, TMRD_WAIT: begin
        if (dly_q == 16'd0) begin
`ifdef SDR_INIT_EXT_MODE_EN
          state_d = EXT_MODE;
          dly_d   = MRD_M1;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = TMRD_WAIT;
          dly_d   = dly_q - 16'd1;
        end
      end
`ifdef SDR_INIT_EXT_MODE_EN
      EXT_MODE, TEMRD_WAIT: begin
        if (dly_q == 16'd0) begin
          state_d = DONE;
        end else begin
          state_d = TEMRD_WAIT;
          dly_d   = dly_q - 16'd1;
        end
      end
`endif
      DONE: begin
        // Re-init skips the power-up wait; CKE is already high.
        if (init_req) begin
          state_d = PRECHARGE;
          dly_d   = RP_M1;
          ref_d   = REF_NUM;
        end
      end
      default: begin
        state_d = IDLE;
        dly_d   = 16'd0;
        ref_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins register together with it.
  always_comb begin
    cke_d  = (state_d != IDLE);
    cmd_d  = CMD_NOP;
    addr_d = 13'h0000;
    ba_d   = 2'b00;
    done_d = (state_d == DONE);
    case (state_d)
      PRECHARGE: begin
        cmd_d  = CMD_PRE;
        addr_d = 13'h0400;
      end
      REFRESH:   cmd_d = CMD_REF;
      LOAD_MODE: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
`ifdef SDR_INIT_EXT_MODE_EN
      EXT_MODE: begin
        cmd_d = CMD_LMR;
        ba_d  = 2'b01;
      end
`endif
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_q       <= IDLE;
      dly_q         <= 16'd0;
      ref_q         <= 8'd0;
      sdr_cke       <= 1'b0;
      sdr_cs_n      <= 1'b1;
      sdr_ras_n     <= 1'b1;
      sdr_cas_n     <= 1'b1;
      sdr_we_n      <= 1'b1;
      sdr_addr      <= 13'h0000;
      sdr_ba        <= 2'b00;
      sdr_init_done <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      ref_q         <= ref_d;
      sdr_cke       <= cke_d;
      sdr_cs_n      <= cmd_d[3];
      sdr_ras_n     <= cmd_d[2];
      sdr_cas_n     <= cmd_d[1];
      sdr_we_n      <= cmd_d[0];
      sdr_addr      <= addr_d;
      sdr_ba        <= ba_d;
      sdr_init_done <= done_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: default-parameter instance plus an all-ones timing instance,
// checked every cycle against an arithmetic command schedule.
module tb_sdram_init_seq;

`ifdef SDR_INIT_EXT_MODE_EN
  localparam int EXT_N = 2;
`else
  localparam int EXT_N = 1;
`endif

  // Instance 0: defaults. Instance 1: minimum timings, two refreshes.
  localparam int A_PWR = 100, A_RP = 3, A_RFC = 7, A_REF = 8, A_MRD = 2;
  localparam int B_PWR = 1, B_RP = 1, B_RFC = 1, B_REF = 2, B_MRD = 1;
  localparam logic [12:0] MODE = 13'h033;
  localparam logic [20:0] RST_VAL = {1'b0, 4'b1111, 13'h0, 2'b00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;

  logic cke0, cs0, ras0, cas0, we0, done0;
  logic cke1, cs1, ras1, cas1, we1, done1;
  logic [12:0] addr0, addr1;
  logic [1:0]  ba0, ba1;
  logic [3:0]  dbg0, dbg1;
  logic [20:0] obs0, obs1;

  assign obs0 = {cke0, cs0, ras0, cas0, we0, addr0, ba0, done0};
  assign obs1 = {cke1, cs1, ras1, cas1, we1, addr1, ba1, done1};

  sdram_init_seq #(
    .T_PWR(A_PWR), .T_RP(A_RP), .T_RFC(A_RFC), .NUM_REF(A_REF), .T_MRD(A_MRD), .MODE_REG(MODE)
  ) dut0 (
    .sdram_clk(clk), .sdram_resetn(rst_n), .init_req(req0),
    .sdr_cke(cke0), .sdr_cs_n(cs0), .sdr_ras_n(ras0), .sdr_cas_n(cas0), .sdr_we_n(we0),
    .sdr_addr(addr0), .sdr_ba(ba0), .sdr_init_done(done0), .dbg_state(dbg0)
  );

  sdram_init_seq #(
    .T_PWR(B_PWR), .T_RP(B_RP), .T_RFC(B_RFC), .NUM_REF(B_REF), .T_MRD(B_MRD), .MODE_REG(MODE)
  ) dut1 (
    .sdram_clk(clk), .sdram_resetn(rst_n), .init_req(req1),
    .sdr_cke(cke1), .sdr_cs_n(cs1), .sdr_ras_n(ras1), .sdr_cas_n(cas1), .sdr_we_n(we1),
    .sdr_addr(addr1), .sdr_ba(ba1), .sdr_init_done(done1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [20:0] exp_q[$];

  // Expected pins at cycle c given the PRECHARGE cycle p. Before p: power-up NOPs when
  // full, otherwise the previous DONE state.
  function automatic logic [20:0] model(int c, int p, bit full, int t_rp, int t_rfc,
                                        int num_ref, int t_mrd);
    int r0, lm, em, dn;
    logic [20:0] r;
    r0 = p + t_rp;
    lm = r0 + num_ref * t_rfc;
    em = (EXT_N == 2) ? lm + t_mrd : -1;
    dn = lm + EXT_N * t_mrd;
    r  = {1'b1, 4'b1111, 13'h0, 2'b00, 1'b0};
    if (c < p) r[0] = !full;
    else if (c == p) r[19:3] = {4'b0010, 13'h0400};
    else if (c >= r0 && c < lm && ((c - r0) % t_rfc) == 0) r[19:16] = 4'b0001;
    else if (c == lm) r[19:3] = {4'b0000, MODE};
    else if (c == em) begin
      r[19:16] = 4'b0000;
      r[2:1]   = 2'b01;
    end
    else if (c >= dn) r[0] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (3) tick();
    exp_q.push_back(RST_VAL);
    exp_q.push_back(RST_VAL);
    e = exp_q.pop_front();
    total_cnt++;
    if (obs0 !== e) $display("FAIL reset dut0 got=%h exp=%h", obs0, e);
    else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++;
    if (obs1 !== e) $display("FAIL reset dut1 got=%h exp=%h", obs1, e);
    else pass_cnt++;
  endtask

  // Full sequence from reset release; init_req pulses land in non-DONE states and must be ignored.
  task automatic test_power_up();
    logic [20:0] e;
    int k1;
    k1 = $urandom_range(1, 4);
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 170; i++) begin
      tick();
      exp_q.push_back(model(cyc, A_PWR + 1, 1, A_RP, A_RFC, A_REF, A_MRD));
      exp_q.push_back(model(cyc, B_PWR + 1, 1, B_RP, B_RFC, B_REF, B_MRD));
      e = exp_q.pop_front();
      total_cnt++;
      if (obs0 !== e) $display("FAIL power_up dut0 cyc=%0d got=%h exp=%h", cyc, obs0, e);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (obs1 !== e) $display("FAIL power_up dut1 cyc=%0d got=%h exp=%h", cyc, obs1, e);
      else pass_cnt++;
      req0 = (cyc == 50);
      req1 = (cyc == k1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Re-init from DONE for dut0 at cycle 200, with a stray pulse mid-sequence; dut1 is
  // re-requested twice, the second time on the very first DONE cycle.
  task automatic test_reinit_back_to_back();
    logic [20:0] e;
    int d1, p1, d2, p2, ig, pc;
    d1 = $urandom_range(171, 200);
    p1 = d1 + 1;
    d2 = p1 + B_RP + B_REF * B_RFC + EXT_N * B_MRD;
    p2 = d2 + 1;
    ig = $urandom_range(202, 261);
    for (int i = 171; i <= 275; i++) begin
      req0 = (cyc == 200) || (cyc == ig);
      req1 = (cyc == d1) || (cyc == d2);
      tick();
      pc = (cyc >= p2) ? p2 : p1;
      exp_q.push_back(model(cyc, 201, 0, A_RP, A_RFC, A_REF, A_MRD));
      exp_q.push_back(model(cyc, pc, 0, B_RP, B_RFC, B_REF, B_MRD));
      e = exp_q.pop_front();
      total_cnt++;
      if (obs0 !== e) $display("FAIL reinit dut0 cyc=%0d got=%h exp=%h", cyc, obs0, e);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (obs1 !== e) $display("FAIL back_to_back dut1 cyc=%0d got=%h exp=%h", cyc, obs1, e);
      else pass_cnt++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Reset dropped mid-sequence must clear pins asynchronously and restart from power-up.
  task automatic test_reset_abort();
    logic [20:0] e;
    int a;
    a = $urandom_range(20, 160);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < a) tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (obs0 !== RST_VAL) $display("FAIL async_reset dut0 cyc=%0d got=%h exp=%h", a, obs0, RST_VAL);
    else pass_cnt++;
    total_cnt++;
    if (obs1 !== RST_VAL) $display("FAIL async_reset dut1 cyc=%0d got=%h exp=%h", a, obs1, RST_VAL);
    else pass_cnt++;
    repeat (2) tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int i = 1; i <= 170; i++) begin
      tick();
      exp_q.push_back(model(cyc, A_PWR + 1, 1, A_RP, A_RFC, A_REF, A_MRD));
      exp_q.push_back(model(cyc, B_PWR + 1, 1, B_RP, B_RFC, B_REF, B_MRD));
      e = exp_q.pop_front();
      total_cnt++;
      if (obs0 !== e) $display("FAIL restart dut0 cyc=%0d got=%h exp=%h", cyc, obs0, e);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (obs1 !== e) $display("FAIL restart dut1 cyc=%0d got=%h exp=%h", cyc, obs1, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_reinit_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
